cvk_filter: RTL and testbench
=============================

CVK_FILTER -- requirements
Module: cvk_filter

Interface
REQ-001 Parameter DATA_WIDTH, default 16, sets the signed fixed-point sample and weight width.
REQ-002 Parameter FRAC_BITS, default 8, sets the fractional bits of samples, weights and results.
REQ-003 Parameter KERNEL_SIZE (K), default 3, sets the kernel rows and columns, range 2..7.
REQ-004 Parameter INPUT_COL_SIZE, default 12, sets the image column height, and SHALL be at least K.
REQ-005 Parameter STRIDE, default 1, sets the horizontal output stride in columns, and SHALL be at least 1.
REQ-006 Localparam PARALLEL_UNITS SHALL equal INPUT_COL_SIZE-K+1.
REQ-007 clk  in  1  is the single clock, and all logic SHALL be rising-edge.
REQ-008 rst  in  1  is the reset, which SHALL be synchronous and active-high.
REQ-009 kernel_load  in  1  marks the accepted column as a kernel column when 1 and an image column when 0.
REQ-010 valid_in  in  1  signals that the input column is valid.
REQ-011 last_in  in  1  marks the last image column of a frame.
REQ-012 input_column  in  INPUT_COL_SIZE x DATA_WIDTH  is the image column, with index 0 as the top row.
REQ-013 kernel_column  in  K x DATA_WIDTH  is the kernel column, with index r as kernel row r.
REQ-014 in_ready  out  1  signals that the block accepts a column on this cycle.
REQ-015 output_column  out  PARALLEL_UNITS x DATA_WIDTH  is the result column.
REQ-016 valid_out  out  1  signals that the result column is valid.
REQ-017 last_out  out  1  marks the final result of a frame.
REQ-018 out_ready  in  1  signals that the downstream block accepts the result.
REQ-019 kernel_valid  out  1  signals that a complete kernel is loaded.
REQ-020 err_no_kernel  out  1  is a sticky flag set when an image column arrives without a complete kernel.

Function
REQ-021 A column SHALL be accepted when valid_in && in_ready, and in_ready SHALL equal !stall.
REQ-022 stall SHALL equal valid_out && !out_ready.
REQ-023 Kernel load SHALL use a counter kcol from 0 to K-1: each accepted kernel column writes weight column kcol, and the first kernel column clears kernel_valid and the window fill count.
REQ-024 The K-th kernel column SHALL set kernel_valid=1 and reset kcol to 0.
REQ-025 An accepted image column while kernel_valid=0 SHALL be dropped, SHALL set err_no_kernel, and SHALL produce no output.
REQ-026 The control state machine SHALL have three states, transitioning S_NOKERNEL -> S_FILL on the K-th kernel column, S_FILL -> S_RUN when K image columns are held, and S_RUN -> S_FILL after the column carrying last_in.
REQ-027 Any kernel column SHALL return the state machine to S_NOKERNEL.
REQ-028 The window SHALL be a shift register of K image columns, with weight column 0 applied to the oldest column.
REQ-029 In S_RUN, the i-th output of the column SHALL equal the sum over c and r of w[c][r]*win[c][i+r].
REQ-030 Output selection: the completing column (the K-th of the frame) SHALL produce output, and thereafter one output SHALL be produced every STRIDE accepted columns.
REQ-031 Arithmetic: products SHALL be 2*DATA_WIDTH bits signed, the accumulator SHALL be 2*DATA_WIDTH+clog2(K*K) bits, and the result SHALL be the accumulator arithmetically shifted right by FRAC_BITS and then narrowed to DATA_WIDTH per REQ-041.
REQ-032 The pipeline SHALL have two stages, stage 1 registering the products and stage 2 registering the sums into the output, so that valid_out rises exactly 2 cycles after acceptance when there is no stall.
REQ-033 When stall=1, both stages and the window SHALL hold, and output_column, valid_out and last_out SHALL remain stable.
REQ-034 last_out SHALL accompany the output of the last_in column if that column produces output; otherwise no last_out is produced for the frame.
REQ-035 After last_in, the fill count SHALL clear, and the next frame SHALL need K columns before it produces output.
REQ-036 A kernel reload SHALL not corrupt results already in stage 1 or stage 2, which SHALL drain with the old weights.

Reset
REQ-037 rst SHALL clear the state to S_NOKERNEL and clear kcol, the fill count, the stride count, valid_out, last_out, kernel_valid, err_no_kernel and both pipeline valid bits.
REQ-038 rst SHALL force output_column to 0 and in_ready to 1.
REQ-039 rst asserted mid-frame or mid-stall SHALL discard all in-flight results on the next edge.
REQ-040 Weights SHALL not be reset, and kernel_valid=0 SHALL gate their use.

Configuration
REQ-041 With CVK_SATURATE_EN defined, out-of-range results SHALL clamp to the signed DATA_WIDTH maximum or minimum; without it, results SHALL keep their low DATA_WIDTH bits (wrap).

Structure
REQ-042 Package cvk_pkg SHALL hold the state enum and the accumulator-width and saturation-limit helper functions.
REQ-043 One sub-module, cvk_pe, SHALL compute one output row (K*K products plus the adder tree), with PARALLEL_UNITS instances.

Verification (K=3, FRAC_BITS=8, INPUT_COL_SIZE=12, 1.0 = 0x0100)
REQ-044 Load an all-0x0100 kernel, stream 4 all-0x0100 columns -> valid_out on cycle acceptance+2 for columns 3 and 4, all 10 outputs = 0x0900.
REQ-045 With STRIDE=2, send 7 columns -> outputs for columns 3, 5 and 7 only; with last_in on column 6 -> outputs for column 3 and 5, and last_out is never asserted.
REQ-046 Hold out_ready=0 for 5 cycles with an output pending -> in_ready=0, the output is held stable, and no column is lost after release.
REQ-047 Use kernel and image of all 0x7F00 -> with CVK_SATURATE_EN, output 0x7FFF; without it, output 0x0900.
REQ-048 Send an image column before the kernel -> err_no_kernel=1 and no valid_out; load 2 of 3 kernel columns, then an image column -> kernel_valid=0 and the error is set.
REQ-049 Assert rst mid-frame with valid_out=1 -> the next cycle shows valid_out=0, kernel_valid=0 and in_ready=1.

Source files
------------

// File: rtl/cvk_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cvk_pkg                                                   |
// | Purpose  : Shared types and sizing helpers for the cvk_filter        |
// |            column-convolution block (state enum, accumulator width,  |
// |            signed saturation limits used when CVK_SATURATE_EN is     |
// |            defined).                                                 |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package cvk_pkg;

  // Control states: no usable kernel, filling the window, producing output
  typedef enum logic [1:0] {
    S_NOKERNEL = 2'd0,
    S_FILL     = 2'd1,
    S_RUN      = 2'd2
  } cvk_state_e;

  // Full-precision accumulator width for K*K signed products
  function automatic int acc_width(input int data_width, input int kernel_size);
    return 2 * data_width + $clog2(kernel_size * kernel_size);
  endfunction

  // Largest representable signed value of the given width
  function automatic longint sat_max(input int data_width);
    return (longint'(1) <<< (data_width - 1)) - longint'(1);
  endfunction

  // Smallest representable signed value of the given width
  function automatic longint sat_min(input int data_width);
    return -(longint'(1) <<< (data_width - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/cvk_pe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cvk_pe                                                    |
// | Purpose  : One output row of the filter: K*K signed products are     |
// |            registered (pipeline stage 1) and summed combinationally  |
// |            into a full-precision accumulator for stage 2.            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module cvk_pe
  import cvk_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 3,
  localparam int ACC_W      = acc_width(DATA_WIDTH, KERNEL_SIZE)
) (
  input  logic                                             clk,
  input  logic                                             en,
  input  logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][DATA_WIDTH-1:0] win,
  input  logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][DATA_WIDTH-1:0] wgt,
  output logic signed [ACC_W-1:0]                          acc
);

  localparam int NPROD = KERNEL_SIZE * KERNEL_SIZE;
  localparam int PW    = 2 * DATA_WIDTH;

  logic signed [PW-1:0] prod_d [NPROD];
  logic signed [PW-1:0] prod_q [NPROD];

  // Multiply each window sample by its weight (index c*K + r)
  always_comb begin
    for (int c = 0; c < KERNEL_SIZE; c++) begin
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        prod_d[c*KERNEL_SIZE + r] = $signed(win[c][r]) * $signed(wgt[c][r]);
      end
    end
  end

  // Stage 1: capture products; held while the pipeline is stalled
  always_ff @(posedge clk) begin
    if (en) begin
      prod_q <= prod_d;
    end
  end

  // Sign-extend and sum all registered products at full precision
  always_comb begin
    acc = '0;
    for (int i = 0; i < NPROD; i++) begin
      acc = acc + {{(ACC_W-PW){prod_q[i][PW-1]}}, prod_q[i]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/cvk_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cvk_filter                                                |
// | Purpose  : Streaming KxK signed fixed-point convolution over image   |
// |            columns. Kernel loaded column by column, window of K      |
// |            image columns, PARALLEL_UNITS rows computed per column,   |
// |            two-stage pipeline with valid/ready flow control.         |
// | Options  : CVK_SATURATE_EN - clamp results to the signed DATA_WIDTH  |
// |            range instead of keeping the low bits.                    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module cvk_filter
  import cvk_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int FRAC_BITS      = 8,
  parameter int KERNEL_SIZE    = 3,
  parameter int INPUT_COL_SIZE = 12,
  parameter int STRIDE         = 1,
  localparam int PARALLEL_UNITS = INPUT_COL_SIZE - KERNEL_SIZE + 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          kernel_load,
  input  logic                                          valid_in,
  input  logic                                          last_in,
  input  logic [INPUT_COL_SIZE-1:0][DATA_WIDTH-1:0]     input_column,
  input  logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0]        kernel_column,
  output logic                                          in_ready,
  output logic [PARALLEL_UNITS-1:0][DATA_WIDTH-1:0]     output_column,
  output logic                                          valid_out,
  output logic                                          last_out,
  input  logic                                          out_ready,
  output logic                                          kernel_valid,
  output logic                                          err_no_kernel
);

  localparam int K     = KERNEL_SIZE;
  localparam int PU    = PARALLEL_UNITS;
  localparam int ACC_W = acc_width(DATA_WIDTH, K);
  localparam int KCW   = $clog2(K);
  localparam int SCW   = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  typedef logic [INPUT_COL_SIZE-1:0][DATA_WIDTH-1:0] col_t;
  typedef logic [K-1:0][K-1:0][DATA_WIDTH-1:0]        kmat_t;

  cvk_state_e          state_q, state_d;
  logic [KCW-1:0]      kcol_q, kcol_d;
  logic [KCW-1:0]      fill_q, fill_d;
  logic [SCW-1:0]      stride_q, stride_d;
  logic                kernel_valid_q, kernel_valid_d;
  logic                err_q, err_d;
  logic                s1_valid_q, s1_valid_d;
  logic                s1_last_q, s1_last_d;
  logic                valid_out_q, valid_out_d;
  logic                last_out_q, last_out_d;
  logic [PU-1:0][DATA_WIDTH-1:0] out_q, out_d;
  kmat_t               wgt_q, wgt_d;
  logic [K-1:0][INPUT_COL_SIZE-1:0][DATA_WIDTH-1:0] win_q, win_d, win_shift;

  logic stall, accept, kern_acc, img_acc, stride_hit, produce;
  logic signed [ACC_W-1:0] pe_acc [PU];
  logic [PU-1:0][DATA_WIDTH-1:0] res;
`ifdef CVK_SATURATE_EN
  logic signed [ACC_W-1:0] shifted;
`endif

  assign stall      = valid_out_q && !out_ready;
  assign in_ready   = !stall;
  assign accept     = valid_in && in_ready;
  assign kern_acc   = accept && kernel_load;
  assign img_acc    = accept && !kernel_load;
  assign stride_hit = (stride_q == SCW'(STRIDE - 1));
  // The completing column of a frame, then every STRIDE-th column, yields output
  assign produce    = img_acc && kernel_valid_q &&
                      (((state_q == S_FILL) && (fill_q == KCW'(K - 1))) ||
                       ((state_q == S_RUN) && stride_hit));

  assign output_column = out_q;
  assign valid_out     = valid_out_q;
  assign last_out      = last_out_q;
  assign kernel_valid  = kernel_valid_q;
  assign err_no_kernel = err_q;

  // Window as it looks once the incoming column is shifted in (oldest at 0)
  always_comb begin
    win_shift = win_q;
    for (int c = 0; c < K - 1; c++) begin
      win_shift[c] = win_q[c + 1];
    end
    win_shift[K-1] = input_column;
  end

  // One processing element per output row, each seeing rows i..i+K-1
  for (genvar gi = 0; gi < PU; gi++) begin : g_pe
    kmat_t pe_win;
    for (genvar gc = 0; gc < K; gc++) begin : g_col
      for (genvar gr = 0; gr < K; gr++) begin : g_row
        assign pe_win[gc][gr] = win_shift[gc][gi + gr];
      end
    end
    cvk_pe #(
      .DATA_WIDTH  (DATA_WIDTH),
      .KERNEL_SIZE (K)
    ) u_pe (
      .clk (clk),
      .en  (!stall),
      .win (pe_win),
      .wgt (wgt_q),
      .acc (pe_acc[gi])
    );
  end

  // Rescale each accumulator to the sample format and fit it into DATA_WIDTH
  always_comb begin
    res = '0;
`ifdef CVK_SATURATE_EN
    shifted = '0;
`endif
    for (int i = 0; i < PU; i++) begin
`ifdef CVK_SATURATE_EN
      shifted = pe_acc[i] >>> FRAC_BITS;
      if (longint'(shifted) > sat_max(DATA_WIDTH)) begin
        res[i] = DATA_WIDTH'(sat_max(DATA_WIDTH));
      end else if (longint'(shifted) < sat_min(DATA_WIDTH)) begin
        res[i] = DATA_WIDTH'(sat_min(DATA_WIDTH));
      end else begin
        res[i] = shifted[DATA_WIDTH-1:0];
      end
`else
      res[i] = DATA_WIDTH'(pe_acc[i] >>> FRAC_BITS);
`endif
    end
  end

  // Kernel loading, window fill/stride bookkeeping and control state
  always_comb begin
    state_d        = state_q;
    kcol_d         = kcol_q;
    fill_d         = fill_q;
    stride_d       = stride_q;
    kernel_valid_d = kernel_valid_q;
    err_d          = err_q;
    wgt_d          = wgt_q;
    win_d          = win_q;
    if (kern_acc) begin
      wgt_d[kcol_q] = kernel_column;
      if (kcol_q == '0) begin
        kernel_valid_d = 1'b0;
        fill_d         = '0;
      end
      if (kcol_q == KCW'(K - 1)) begin
        kcol_d         = '0;
        kernel_valid_d = 1'b1;
        state_d        = S_FILL;
        fill_d         = '0;
        stride_d       = '0;
      end else begin
        kcol_d  = kcol_q + KCW'(1);
        state_d = S_NOKERNEL;
      end
    end else if (img_acc) begin
      if (!kernel_valid_q) begin
        err_d = 1'b1;
      end else begin
        win_d = win_shift;
        if (state_q == S_FILL) begin
          if (fill_q == KCW'(K - 1)) begin
            state_d  = S_RUN;
            stride_d = '0;
          end else begin
            fill_d = fill_q + KCW'(1);
          end
        end else if (state_q == S_RUN) begin
          stride_d = stride_hit ? '0 : stride_q + SCW'(1);
        end
        if (last_in) begin
          state_d  = S_FILL;
          fill_d   = '0;
          stride_d = '0;
        end
      end
    end
  end

  // Two-stage result pipeline; everything holds while the output is stalled
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    valid_out_d = valid_out_q;
    last_out_d  = last_out_q;
    out_d       = out_q;
    if (!stall) begin
      s1_valid_d  = produce;
      s1_last_d   = produce && last_in;
      valid_out_d = s1_valid_q;
      last_out_d  = s1_last_q;
      if (s1_valid_q) begin
        out_d = res;
      end
    end
  end

  // Control and pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_NOKERNEL;
      kcol_q         <= '0;
      fill_q         <= '0;
      stride_q       <= '0;
      kernel_valid_q <= 1'b0;
      err_q          <= 1'b0;
      s1_valid_q     <= 1'b0;
      s1_last_q      <= 1'b0;
      valid_out_q    <= 1'b0;
      last_out_q     <= 1'b0;
      out_q          <= '0;
    end else begin
      state_q        <= state_d;
      kcol_q         <= kcol_d;
      fill_q         <= fill_d;
      stride_q       <= stride_d;
      kernel_valid_q <= kernel_valid_d;
      err_q          <= err_d;
      s1_valid_q     <= s1_valid_d;
      s1_last_q      <= s1_last_d;
      valid_out_q    <= valid_out_d;
      last_out_q     <= last_out_d;
      out_q          <= out_d;
    end
  end

  // Weights and window are pure data; kernel_valid gates their use
  always_ff @(posedge clk) begin
    wgt_q <= wgt_d;
    win_q <= win_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_cvk_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_cvk_filter                                             |
// | Purpose  : Directed self-checking bench for cvk_filter (K=3,         |
// |            FRAC_BITS=8, 12-row columns); STRIDE=1 and STRIDE=2 DUTs. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_cvk_filter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic kernel_load = 1'b0;
  logic valid1 = 1'b0;
  logic valid2 = 1'b0;
  logic last_in = 1'b0;
  logic out_ready = 1'b1;
  logic [11:0][15:0] input_column = '0;
  logic [2:0][15:0]  kernel_column = '0;

  logic ir1, vo1, lo1, kv1, err1;
  logic ir2, vo2, lo2, kv2, err2;
  logic [9:0][15:0] oc1, oc2;

  int checks = 0;
  int errors = 0;

  logic [159:0] oq[$];
  int           idxq[$];
  bit           lq[$];

  always #5 clk = ~clk;

  cvk_filter #(.DATA_WIDTH(16), .FRAC_BITS(8), .KERNEL_SIZE(3),
               .INPUT_COL_SIZE(12), .STRIDE(1)) dut1 (
    .clk(clk), .rst(rst), .kernel_load(kernel_load), .valid_in(valid1),
    .last_in(last_in), .input_column(input_column), .kernel_column(kernel_column),
    .in_ready(ir1), .output_column(oc1), .valid_out(vo1), .last_out(lo1),
    .out_ready(out_ready), .kernel_valid(kv1), .err_no_kernel(err1));

  cvk_filter #(.DATA_WIDTH(16), .FRAC_BITS(8), .KERNEL_SIZE(3),
               .INPUT_COL_SIZE(12), .STRIDE(2)) dut2 (
    .clk(clk), .rst(rst), .kernel_load(kernel_load), .valid_in(valid2),
    .last_in(last_in), .input_column(input_column), .kernel_column(kernel_column),
    .in_ready(ir2), .output_column(oc2), .valid_out(vo2), .last_out(lo2),
    .out_ready(out_ready), .kernel_valid(kv2), .err_no_kernel(err2));

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [159:0] rep(input logic [15:0] v);
    logic [159:0] r;
    for (int i = 0; i < 10; i++) r[i*16 +: 16] = v;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid1 = 1'b0; valid2 = 1'b0; kernel_load = 1'b0; last_in = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic img_const(input logic [15:0] v);
    for (int r = 0; r < 12; r++) input_column[r] = v;
  endtask

  task automatic load_kernel(input int sel, input logic [15:0] v);
    for (int r = 0; r < 3; r++) kernel_column[r] = v;
    kernel_load = 1'b1;
    valid1 = (sel == 1);
    valid2 = (sel == 2);
    repeat (3) step();
    idle();
  endtask

  // Stream ncols columns (value n.0 in every row) into dut2, logging outputs
  task automatic run_frame2(input int ncols, input int last_col);
    oq.delete(); idxq.delete(); lq.delete();
    for (int k = 1; k <= ncols + 3; k++) begin
      if (k <= ncols) begin
        img_const(16'(k * 256));
        valid2 = 1'b1;
        last_in = (k == last_col);
      end else begin
        idle();
      end
      step();
      if (vo2) begin
        oq.push_back(oc2);
        idxq.push_back(k);
        lq.push_back(lo2);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [159:0] e3, e4;
    logic [15:0]  sat_exp;

    // Reset state
    step();
    chk("rst_valid_out", vo1, 1'b0);
    chk("rst_kernel_valid", kv1, 1'b0);
    chk("rst_in_ready", ir1, 1'b1);
    chk("rst_err", err1, 1'b0);
    chk("rst_last_out", lo1, 1'b0);
    chk("rst_out_col", oc1, '0);
    rst = 1'b0;

    // Image column before any kernel
    img_const(16'h0100); valid1 = 1'b1;
    step(); idle();
    chk("nok_err", err1, 1'b1);
    step(); chk("nok_vo_a", vo1, 1'b0);
    step(); chk("nok_vo_b", vo1, 1'b0);
    chk("nok_kv", kv1, 1'b0);

    // Partial kernel (2 of 3) then an image column
    do_reset();
    chk("rst_err_clear", err1, 1'b0);
    for (int r = 0; r < 3; r++) kernel_column[r] = 16'h0100;
    kernel_load = 1'b1; valid1 = 1'b1;
    step(); step();
    kernel_load = 1'b0;
    step(); idle();
    chk("part_kv", kv1, 1'b0);
    chk("part_err", err1, 1'b1);
    step(); step(); chk("part_vo", vo1, 1'b0);

    // All-ones kernel and image: 9 * 1.0 in every row
    do_reset();
    load_kernel(1, 16'h0100);
    chk("ones_kv", kv1, 1'b1);
    img_const(16'h0100); valid1 = 1'b1;
    step(); step(); step();
    chk("ones_vo_c3acc", vo1, 1'b0);
    step(); idle();
    chk("ones_vo_c3", vo1, 1'b1);
    chk("ones_out_c3", oc1, rep(16'h0900));
    step();
    chk("ones_vo_c4", vo1, 1'b1);
    chk("ones_out_c4", oc1, rep(16'h0900));
    step();
    chk("ones_vo_end", vo1, 1'b0);

    // Sparse mixed-sign kernel: w[0][0]=1.0, w[1][1]=-1.0, w[2][2]=2.0
    kernel_load = 1'b1; valid1 = 1'b1;
    kernel_column = '0; kernel_column[0] = 16'h0100; step();
    kernel_column = '0; kernel_column[1] = 16'hFF00; step();
    kernel_column = '0; kernel_column[2] = 16'h0200; step();
    kernel_load = 1'b0;
    for (int i = 0; i < 10; i++) begin
      e3[i*16 +: 16] = 16'h0530 + 16'(i * 32);
      e4[i*16 +: 16] = 16'h0730 + 16'(i * 32);
    end
    for (int n = 1; n <= 4; n++) begin
      for (int r = 0; r < 12; r++) input_column[r] = 16'(n * 256 + r * 16);
      last_in = (n == 4);
      step();
      if (n == 3) chk("mix_vo_c3acc", vo1, 1'b0);
    end
    idle();
    chk("mix_vo_c3", vo1, 1'b1);
    chk("mix_out_c3", oc1, e3);
    chk("mix_lo_c3", lo1, 1'b0);
    step();
    chk("mix_out_c4", oc1, e4);
    chk("mix_lo_c4", lo1, 1'b1);
    step();
    chk("mix_vo_end", vo1, 1'b0);
    chk("mix_lo_end", lo1, 1'b0);

    // Output back-pressure for 5 cycles with a result pending
    load_kernel(1, 16'h0100);
    out_ready = 1'b0;
    valid1 = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      img_const(16'(n * 256));
      step();
    end
    chk("stl_vo_pre", vo1, 1'b0);
    img_const(16'h0400);
    step();
    chk("stl_vo", vo1, 1'b1);
    chk("stl_in_ready", ir1, 1'b0);
    chk("stl_out", oc1, rep(16'h1200));
    img_const(16'h0500);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stl_hold_ir", ir1, 1'b0);
      chk("stl_hold_vo", vo1, 1'b1);
      chk("stl_hold_out", oc1, rep(16'h1200));
    end
    out_ready = 1'b1;
    step(); idle();
    chk("stl_rel_vo_c4", vo1, 1'b1);
    chk("stl_rel_out_c4", oc1, rep(16'h1B00));
    step();
    chk("stl_rel_vo_c5", vo1, 1'b1);
    chk("stl_rel_out_c5", oc1, rep(16'h2400));
    step();
    chk("stl_rel_vo_end", vo1, 1'b0);

    // Out-of-range result: 9 * (127.0 * 127.0)
`ifdef CVK_SATURATE_EN
    sat_exp = 16'h7FFF;
`else
    sat_exp = 16'h0900;
`endif
    load_kernel(1, 16'h7F00);
    img_const(16'h7F00); valid1 = 1'b1;
    repeat (4) step();
    idle();
    chk("sat_vo", vo1, 1'b1);
    chk("sat_out", oc1, rep(sat_exp));

    // Reset with an output valid and another result in stage 1
    rst = 1'b1;
    step();
    chk("mrst_vo", vo1, 1'b0);
    chk("mrst_kv", kv1, 1'b0);
    chk("mrst_ir", ir1, 1'b1);
    chk("mrst_out", oc1, '0);
    rst = 1'b0;
    step();
    chk("mrst_vo_drain", vo1, 1'b0);

    // STRIDE=2: 7 columns, last on column 7
    load_kernel(2, 16'h0100);
    chk("s2_kv", kv2, 1'b1);
    run_frame2(7, 7);
    chk("s2a_count", oq.size(), 3);
    chk("s2a_idx0", idxq[0], 4);
    chk("s2a_idx1", idxq[1], 6);
    chk("s2a_idx2", idxq[2], 8);
    chk("s2a_out0", oq[0], rep(16'h1200));
    chk("s2a_out1", oq[1], rep(16'h2400));
    chk("s2a_out2", oq[2], rep(16'h3600));
    chk("s2a_last0", lq[0], 1'b0);
    chk("s2a_last2", lq[2], 1'b1);

    // STRIDE=2: 6 columns, last on column 6 (which produces nothing)
    run_frame2(6, 6);
    chk("s2b_count", oq.size(), 2);
    chk("s2b_out0", oq[0], rep(16'h1200));
    chk("s2b_out1", oq[1], rep(16'h2400));
    chk("s2b_last0", lq[0], 1'b0);
    chk("s2b_last1", lq[1], 1'b0);
    chk("s2_err", err2, 1'b0);
    chk("s2_ir", ir2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
